iob_timer_mc: RTL

Multi-channel programmable timer on the native iob slave bus. It generalises the single free-running counter into N_CH independent channels. Each channel adds a prescaler, a wide counter, compare match, one-shot or periodic mode and a maskable interrupt. It sits beside the CPU in the peripheral address space and drives per-channel and combined interrupt lines.

---
 rtl/iob_timer_mc_pkg.sv | 26 ++
 rtl/iob_timer_mc_if.sv | 15 +
 rtl/iob_timer_mc_ch.sv | 126 ++++++++++++
 rtl/iob_timer_mc.sv | 72 +++++++
 4 files changed

// File: rtl/iob_timer_mc_pkg.sv
// Shared register indices, CTRL/STATUS bit positions and address split
// for the multi-channel timer.
package iob_timer_mc_pkg;

  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_PRESC    = 3'd1,
    REG_CMP_LO   = 3'd2,
    REG_CMP_HI   = 3'd3,
    REG_CNT_LO   = 3'd4,
    REG_CNT_HI   = 3'd5,
    REG_STATUS   = 3'd6,
    REG_UNMAPPED = 3'd7
  } reg_idx_e;

  localparam int CTRL_RUN      = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_CLEAR    = 3;

  localparam int STAT_MATCH    = 0;
  localparam int STAT_RUNNING  = 1;

  localparam int CH_LSB        = 3;

endpackage

// File: rtl/iob_timer_mc_if.sv
// Native iob bus bundle between a CPU-side master and the timer slave.
interface iob_timer_mc_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic                valid;
  logic [ADDR_W-1:0]   address;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [DATA_W-1:0]   rdata;
  logic                ready;

  modport master (output valid, address, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, address, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/iob_timer_mc_ch.sv
// One timer channel: prescaler, wide counter with compare, CTRL/STATUS
// registers and the CNT_HI read snapshot.
module iob_timer_ch
  import iob_timer_mc_pkg::*;
#(
  parameter int CNT_W   = 64,
  parameter int PRESC_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  reg_idx_e    widx_i,
  input  logic [31:0] wdata_i,
  input  logic        re_i,
  input  reg_idx_e    ridx_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);
  localparam int HI_W = CNT_W - 32;

  logic               run_q, run_d, periodic_q, periodic_d, irq_en_q, irq_en_d;
  logic               match_q, match_d;
  logic [PRESC_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
  logic [CNT_W-1:0]   cmp_q, cmp_d, cnt_q, cnt_d;
  logic [HI_W-1:0]    shadow_q;
  logic               tick, cnt_wr, match_set, w1c;

  // >= rather than == so a PRESC write below the running prescaler ticks at once
  assign tick  = run_q && (pcnt_q >= presc_q);
  assign irq_o = match_q & irq_en_q;

  always_comb begin
    run_d      = run_q;
    periodic_d = periodic_q;
    irq_en_d   = irq_en_q;
    presc_d    = presc_q;
    cmp_d      = cmp_q;
    cnt_d      = cnt_q;
    pcnt_d     = pcnt_q;
    match_set  = 1'b0;
    w1c        = 1'b0;
    cnt_wr     = we_i && (widx_i == REG_CNT_LO || widx_i == REG_CNT_HI ||
                          (widx_i == REG_CTRL && wdata_i[CTRL_CLEAR]));

    if (run_q) pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);

    if (tick && !cnt_wr) begin
      if (cnt_q == cmp_q) begin
        match_set = 1'b1;
        if (periodic_q) cnt_d = '0;
        else            run_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (we_i) begin
      case (widx_i)
        REG_CTRL: begin
          run_d      = wdata_i[CTRL_RUN];
          periodic_d = wdata_i[CTRL_PERIODIC];
          irq_en_d   = wdata_i[CTRL_IRQ_EN];
          if (wdata_i[CTRL_CLEAR]) begin
            cnt_d  = '0;
            pcnt_d = '0;
          end
        end
        REG_PRESC:  presc_d = wdata_i[PRESC_W-1:0];
        REG_CMP_LO: cmp_d[31:0] = wdata_i;
        REG_CMP_HI: cmp_d[CNT_W-1:32] = wdata_i[HI_W-1:0];
        REG_CNT_LO: begin
          cnt_d[31:0] = wdata_i;
          pcnt_d      = '0;
        end
        REG_CNT_HI: begin
          cnt_d[CNT_W-1:32] = wdata_i[HI_W-1:0];
          pcnt_d            = '0;
        end
        REG_STATUS: w1c = wdata_i[STAT_MATCH];
        default: ;
      endcase
    end

    match_d = (match_q & ~w1c) | match_set;
  end

  always_comb begin
    rdata_o = '0;
    case (ridx_i)
      REG_CTRL:   rdata_o = {29'd0, irq_en_q, periodic_q, run_q};
      REG_PRESC:  rdata_o = 32'(presc_q);
      REG_CMP_LO: rdata_o = cmp_q[31:0];
      REG_CMP_HI: rdata_o = 32'(cmp_q[CNT_W-1:32]);
      REG_CNT_LO: rdata_o = cnt_q[31:0];
      REG_CNT_HI: rdata_o = 32'(shadow_q);
      REG_STATUS: rdata_o = {30'd0, run_q, match_q};
      default:    rdata_o = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_q      <= 1'b0;
      periodic_q <= 1'b0;
      irq_en_q   <= 1'b0;
      match_q    <= 1'b0;
      presc_q    <= '0;
      pcnt_q     <= '0;
      cmp_q      <= '0;
      cnt_q      <= '0;
      shadow_q   <= '0;
    end else begin
      run_q      <= run_d;
      periodic_q <= periodic_d;
      irq_en_q   <= irq_en_d;
      match_q    <= match_d;
      presc_q    <= presc_d;
      pcnt_q     <= pcnt_d;
      cmp_q      <= cmp_d;
      cnt_q      <= cnt_d;
      // LO read captures HI so a LO-then-HI pair is coherent across a carry
      if (re_i && ridx_i == REG_CNT_LO) shadow_q <= cnt_q[CNT_W-1:32];
    end
  end

endmodule

// File: rtl/iob_timer_mc.sv
// Multi-channel timer on the iob slave bus: address decode, registered
// read mux, single-cycle ready and combined interrupt.
module iob_timer_mc
  import iob_timer_mc_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int N_CH    = 4,
  parameter int CNT_W   = 64,
  parameter int PRESC_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  iob_timer_mc_if.slave   bus,
  output logic [N_CH-1:0] irq,
  output logic            irq_any
);
  localparam int CH_W = ADDR_W - CH_LSB;

  logic [CH_W-1:0]   ch_sel;
  reg_idx_e          reg_idx;
  logic              is_wr, in_range;
  logic [DATA_W-1:0] ch_rdata [N_CH];
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic              ready_q;

  assign ch_sel   = bus.address[ADDR_W-1:CH_LSB];
  assign reg_idx  = reg_idx_e'(bus.address[CH_LSB-1:0]);
  assign is_wr    = |bus.wstrb;
  assign in_range = int'(ch_sel) < N_CH;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    iob_timer_ch #(
      .CNT_W   (CNT_W),
      .PRESC_W (PRESC_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .we_i    (bus.valid && is_wr && in_range && ch_sel == CH_W'(g)),
      .widx_i  (reg_idx),
      .wdata_i (bus.wdata),
      .re_i    (bus.valid && !is_wr && in_range && ch_sel == CH_W'(g)),
      .ridx_i  (reg_idx),
      .rdata_o (ch_rdata[g]),
      .irq_o   (irq[g])
    );
  end

  always_comb begin
    rdata_d = '0;
    if (bus.valid && !is_wr && in_range) begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_sel == CH_W'(i)) rdata_d = ch_rdata[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= bus.valid;
      rdata_q <= rdata_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign irq_any   = |irq;

endmodule
